// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
package dff_arb_pkg;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        ACK   = ST_ACK
    } state_t;

    // Owner/pointer index width; a single requester still needs one bit.
    function automatic int unsigned owner_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_reg.sv
// W-bit enable D register with synchronous active-high reset.
module dff_reg #(
    parameter int unsigned      W         = 8,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared enable-DFF register.
// Optional ownership lock (lock port, LOCK_MAX) is built when DFF_ARB_LOCK_EN is defined.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned  N         = DEF_N,
    parameter int unsigned  W         = DEF_W,
    parameter logic [W-1:0] RESET_VAL = '0
`ifdef DFF_ARB_LOCK_EN
    ,
    parameter int unsigned  LOCK_MAX  = 4
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 req,
    input  logic [N*W-1:0]               wdata,
`ifdef DFF_ARB_LOCK_EN
    input  logic [N-1:0]                 lock,
`endif
    output logic [N-1:0]                 gnt,
    output logic [N-1:0]                 ack,
    output logic [W-1:0]                 q,
    output logic                         busy,
    output logic [owner_width(N)-1:0]    owner
);

    localparam int unsigned OW = owner_width(N);

    state_t        state;
    state_t        state_n;
    logic [OW-1:0] owner_n;
    logic [OW-1:0] ptr;
    logic [OW-1:0] ptr_n;
    logic [N-1:0]  gnt_n;
    logic [N-1:0]  ack_n;
    logic          busy_n;
    logic          en;
    logic [W-1:0]  d;

`ifdef DFF_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] lock_cnt_n;
`endif

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        return (32'(i) == N - 1) ? '0 : OW'(32'(i) + 1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [OW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First set request scanning upward from p with wrap-around.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
        logic [OW-1:0] w;
        logic [OW-1:0] idx;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = OW'((32'(p) + i) % N);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Write data slice of the current owner.
    always_comb begin
        d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (OW'(i) == owner) begin
                d = wdata[i*W +: W];
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        en      = 1'b0;
`ifdef DFF_ARB_LOCK_EN
        lock_cnt_n = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    owner_n = rr_pick(req, ptr);
                end
            end
            GRANT: begin
                if (req[owner]) begin
                    en      = 1'b1;
                    state_n = ACK;
                end else begin
                    state_n = IDLE;
                    ptr_n   = next_idx(owner);
                end
            end
            ACK: begin
`ifdef DFF_ARB_LOCK_EN
                if (lock[owner] && req[owner] && (lock_cnt < CW'(LOCK_MAX - 1))) begin
                    state_n    = GRANT;
                    lock_cnt_n = lock_cnt + CW'(1);
                end else begin
                    state_n = IDLE;
                    ptr_n   = next_idx(owner);
                end
`else
                state_n = IDLE;
                ptr_n   = next_idx(owner);
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
`ifdef DFF_ARB_LOCK_EN
        if (state_n == IDLE) begin
            lock_cnt_n = '0;
        end
`endif
        busy_n = (state_n != IDLE);
        gnt_n  = busy_n ? onehot(owner_n) : '0;
        ack_n  = (state_n == ACK) ? onehot(owner_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            gnt   <= '0;
            ack   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            busy  <= busy_n;
        end
    end

`ifdef DFF_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_n;
        end
    end
`endif

    dff_reg #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomized transaction-level bench for dff_bank_arbiter against a round-robin reference model.
module tb_dff_bank_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
`ifdef DFF_ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [1:0]     owner;

    int checks = 0;
    int errors = 0;

    int           m_ptr;
    logic [W-1:0] m_q;
    logic [W-1:0] m_data [N];

    always #5 clk = ~clk;

    dff_bank_arbiter #(
        .N         (N),
        .W         (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
`ifdef DFF_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy),
        .owner (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            m_data[i] = W'($urandom);
            wdata[i*W +: W] = m_data[i];
        end
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        m_data[i] = v;
        wdata[i*W +: W] = v;
    endtask

    // One arbitration round starting from IDLE at a falling edge; returns in IDLE.
    task automatic txn(input logic [N-1:0] r, input bit withdraw);
        int           w;
        logic [N-1:0] oh;
        req = r;
        w   = pick(r, m_ptr);
        step();
        if (w < 0) begin
            check("idle_busy", 32'(busy), 0);
            check("idle_gnt", 32'(gnt), 0);
            check("idle_q", 32'(q), 32'(m_q));
            return;
        end
        oh    = '0;
        oh[w] = 1'b1;
        check("grant_gnt", 32'(gnt), 32'(oh));
        check("grant_owner", 32'(owner), 32'(w));
        check("grant_busy", 32'(busy), 1);
        check("grant_ack", 32'(ack), 0);
        check("grant_q", 32'(q), 32'(m_q));
        if (withdraw) begin
            req[w] = 1'b0;
            step();
            check("wd_gnt", 32'(gnt), 0);
            check("wd_ack", 32'(ack), 0);
            check("wd_busy", 32'(busy), 0);
            check("wd_q", 32'(q), 32'(m_q));
        end else begin
            step();
            m_q = m_data[w];
            check("ack_q", 32'(q), 32'(m_q));
            check("ack_ack", 32'(ack), 32'(oh));
            check("ack_gnt", 32'(gnt), 32'(oh));
            step();
            check("rel_gnt", 32'(gnt), 0);
            check("rel_ack", 32'(ack), 0);
            check("rel_busy", 32'(busy), 0);
            check("rel_q", 32'(q), 32'(m_q));
        end
        m_ptr = (w + 1) % N;
        req   = '0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '1;
        wdata = '0;
`ifdef DFF_ARB_LOCK_EN
        lock  = '0;
`endif
        repeat (2) begin
            step();
            check("rst_gnt", 32'(gnt), 0);
            check("rst_ack", 32'(ack), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_q", 32'(q), 0);
            check("rst_owner", 32'(owner), 0);
        end
        reset = 1'b0;
        req   = '0;
        m_ptr = 0;
        m_q   = '0;

        // Single request with known data.
        drive_data();
        set_data(2, 8'hA5);
        txn(4'b0100, 1'b0);

        // All requesting: strict rotation.
        for (int k = 0; k < 5; k++) begin
            drive_data();
            txn(4'b1111, 1'b0);
        end

        // Move pointer to 3, then wrap 3 -> 0.
        drive_data();
        txn(4'b0100, 1'b0);
        drive_data();
        txn(4'b1001, 1'b0);
        drive_data();
        txn(4'b1001, 1'b0);

        // Withdrawal during GRANT.
        drive_data();
        txn(4'b0001, 1'b1);

        // Reset during GRANT aborts the write.
        drive_data();
        set_data(2, 8'h3C);
        req = 4'b0100;
        step();
        check("abort_gnt_pre", 32'(gnt), 32'(4'b0100));
        reset = 1'b1;
        step();
        check("abort_q", 32'(q), 0);
        check("abort_gnt", 32'(gnt), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_owner", 32'(owner), 0);
        reset = 1'b0;
        req   = '0;
        m_ptr = 0;
        m_q   = '0;
        step();
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_ack", 32'(ack), 0);
        drive_data();
        txn(4'b1111, 1'b0);

`ifdef DFF_ARB_LOCK_EN
        begin
            int n0;
            n0 = 0;
            drive_data();
            lock = 4'b0011;
            req  = 4'b0011;
            m_ptr = pick(4'b0011, m_ptr);
            for (int k = 0; k < 10; k++) begin
                step();
                if (ack == 4'b0001) n0++;
            end
            check("lock_acks0", 32'(n0), 4);
            check("lock_next_gnt", 32'(gnt), 32'(4'b0010));
            check("lock_q", 32'(q), 32'(m_data[0]));
            m_q  = m_data[0];
            req  = '0;
            lock = '0;
            step();
            check("lock_wd_busy", 32'(busy), 0);
            m_ptr = 2;
        end
`endif

        // Randomized rounds, occasional withdrawals and empty cycles.
        for (int k = 0; k < 60; k++) begin
            drive_data();
            txn(N'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
